dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The state enum, the word/lane geometry and the address error check live here.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = WORD_W / LANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Flags a request that is not word aligned or whose word index lies past the array.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input int unsigned        depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous byte-enabled write and registered read.
// There is no reset, so contents survive a responder reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [LANES-1:0]  be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (be[i]) begin
            mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one request in IDLE,
// waits a fixed number of cycles, then presents the response until consumed.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [LANES-1:0]  req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              cap_we;
  logic [WORD_W-1:0] cap_addr;
  logic [WORD_W-1:0] cap_wdata;
  logic [LANES-1:0]  cap_be;

  logic              accept;
  logic              enter_resp;
  logic              sel_we;
  logic [WORD_W-1:0] sel_addr;
  logic [WORD_W-1:0] sel_wdata;
  logic [LANES-1:0]  sel_be;
  logic              mem_en;
  logic              cap_err;
  logic [WORD_W-1:0] arr_rdata;

  assign accept = req_valid && req_ready;

  // With no wait stage the array is touched on the acceptance edge itself,
  // so the live request fields feed it instead of the not-yet-captured copy.
  always_comb begin
    sel_we    = cap_we;
    sel_addr  = cap_addr;
    sel_wdata = cap_wdata;
    sel_be    = cap_be;
    if (state == IDLE) begin
      sel_we    = req_we;
      sel_addr  = req_addr;
      sel_wdata = req_wdata;
      sel_be    = req_be;
    end
  end

  assign enter_resp = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == 4'd0));
  assign mem_en     = enter_resp && !addr_err(sel_addr, DEPTH_WORDS);
  assign cap_err    = addr_err(cap_addr, DEPTH_WORDS);

  dmem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (sel_we),
    .addr  (sel_addr[AW+1:2]),
    .wdata (sel_wdata),
    .be    (sel_be),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = reset && (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) && cap_err;
    rsp_rdata = '0;
    if ((state == RESP) && !cap_we && !cap_err) begin
      rsp_rdata = arr_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
    end else if (accept) begin
      cap_we    <= req_we;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_be    <= req_be;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for the main
// sequence and a WAIT_CYCLES=0 instance for the zero-wait latency case.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic [3:0]  b_req_be = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance. Called #1 after a rising edge.
  // During the hold cycles a stray request is presented and must be ignored.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold,
                      output logic [31:0] rdata, output logic err, output int latency);
    int guard = 0;
    while (!req_ready && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    latency = 1;
    while (!rsp_valid && latency < 40) begin
      @(posedge clk); #1; latency++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = '0; req_be = 4'hF;
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, rdata);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("idle_after_consume", 32'(rsp_valid), 32'd0);
    check("ready_after_consume", 32'(req_ready), 32'd1);
  endtask

  task automatic xact0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int latency);
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_be = 4'hF;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    latency = 1;
    while (!b_rsp_valid && latency < 40) begin
      @(posedge clk); #1; latency++;
    end
    rdata = b_rsp_rdata;
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    check("st10_err", 32'(er), 32'd0);
    check("st10_rdata", rd, 32'd0);
    check("st10_lat", 32'(lat), 32'd3);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld10_rdata", rd, 32'hDEADBEEF);
    check("ld10_err", 32'(er), 32'd0);
    check("ld10_lat", 32'(lat), 32'd3);

    xact(1'b1, 32'h10, 32'h000000AA, 4'h1, 0, rd, er, lat);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld10_merged", rd, 32'hDEADBEAA);

    xact(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat);
    check("st_be0_err", 32'(er), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld_after_be0", rd, 32'hDEADBEAA);

    xact(1'b0, 32'h12, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld12_err", 32'(er), 32'd1);
    check("ld12_rdata", rd, 32'd0);
    xact(1'b1, 32'hFC, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
    check("stFC_err", 32'(er), 32'd0);
    xact(1'b1, 32'h100, 32'h11111111, 4'hF, 0, rd, er, lat);
    check("st100_err", 32'(er), 32'd1);
    xact(1'b0, 32'hFC, 32'h0, 4'h0, 0, rd, er, lat);
    check("ldFC_rdata", rd, 32'hCAFEF00D);
    xact(1'b0, 32'h100, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld100_err", 32'(er), 32'd1);
    check("ld100_rdata", rd, 32'd0);

    xact(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
    check("hold_ld_rdata", rd, 32'hDEADBEAA);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("stray_req_ignored", rd, 32'hDEADBEAA);

    rsp_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_rsp_ready_ign", 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b0;

    xact(1'b1, 32'h20, 32'h12345678, 4'hF, 0, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h99999999; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wait_no_rsp", 32'(rsp_valid), 32'd0);
    check("wait_not_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_rdata", rsp_rdata, 32'd0);
    check("abort_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld20_kept", rd, 32'h12345678);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld10_survives_rst", rd, 32'hDEADBEAA);

    check("w0_ready", 32'(b_req_ready), 32'd1);
    xact0(1'b1, 32'h10, 32'h0BADCAFE, rd, lat);
    check("w0_st_lat", 32'(lat), 32'd1);
    xact0(1'b0, 32'h10, 32'h0, rd, lat);
    check("w0_ld_lat", 32'(lat), 32'd1);
    check("w0_ld_rdata", rd, 32'h0BADCAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
